// File: rtl/dab_phase_shift_pwm.sv
// dab_phase_shift_pwm: shared-carrier 3-level phase-shift PWM for N_BR H-bridges.
// Optional dead-time insertion is built when DAB_DEADTIME_EN is defined.
module dab_phase_shift_pwm #(
    parameter int CNT_W = 19,
    parameter int N_BR  = 2,
    parameter int DT_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_sync,
    input  logic [CNT_W-1:0]          i_half_period,
    input  logic [N_BR*CNT_W-1:0]     i_tau,
    input  logic [N_BR*(CNT_W+1)-1:0] i_phase,
    input  logic [DT_W-1:0]           i_deadtime,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    output logic [4*N_BR-1:0]         o_gate,
    output logic [2*N_BR-1:0]         o_v_level,
    output logic                      o_period_tick,
    output logic                      o_running
);
    localparam int SW = CNT_W + 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W:0]        r_cnt;
    logic                  r_full;
    logic                  r_tick;
    logic [CNT_W-1:0]      r_sh_p;
    logic [CNT_W-1:0]      r_p;
    logic [CNT_W-1:0]      r_sh_tau [N_BR];
    logic [CNT_W-1:0]      r_tau    [N_BR];
    logic signed [CNT_W:0] r_sh_ph  [N_BR];
    logic signed [CNT_W:0] r_ph     [N_BR];
    logic [2*N_BR-1:0]     r_vlev;
    logic [4*N_BR-1:0]     r_gate;

    logic [1:0]            w_state_nx;
    logic                  w_wrap;
    logic                  w_realign;
    logic                  w_apply;
    logic                  w_cap;
    logic [CNT_W-1:0]      w_p_cl;
    logic signed [SW-1:0]  w_cnt_s;
    logic signed [SW-1:0]  w_p_s;
    logic signed [SW-1:0]  w_p2;
    logic signed [SW-1:0]  w_p2m1;
    logic signed [SW-1:0]  w_d [N_BR];
    logic signed [SW-1:0]  w_l [N_BR];
    logic signed [SW-1:0]  w_t [N_BR];
    logic [1:0]            w_lvl [N_BR];
    logic [2*N_BR-1:0]     w_lvl_v;
    logic [4*N_BR-1:0]     w_des;
    logic                  w_unused_ph0;

    assign w_unused_ph0 = ^i_phase[CNT_W:0];
    assign w_cnt_s      = $signed({1'b0, r_cnt});
    assign w_p_s        = $signed({2'b00, r_p});
    assign w_p2         = $signed({1'b0, r_p, 1'b0});
    assign w_p2m1       = w_p2 - SW'(1);
    assign w_wrap       = (r_state != IDLE) && (w_cnt_s >= w_p2m1);
    assign w_realign    = (r_state == RUN) && i_sync;
    assign w_cap        = i_cfg_valid && !r_full;
    assign w_apply      = r_full && ((r_state == IDLE) || w_wrap || w_realign);
    assign w_p_cl       = (i_half_period < CNT_W'(2)) ? CNT_W'(2) : i_half_period;
    assign w_state_nx   = (r_state == IDLE) ? ((i_en && i_sync) ? RUN : IDLE) :
                          (r_state == RUN)  ? (i_en ? RUN : (w_wrap && !w_realign) ? IDLE : STOP) :
                          (w_wrap ? IDLE : STOP);

    assign o_cfg_ready   = !r_full;
    assign o_gate        = r_gate;
    assign o_v_level     = r_vlev;
    assign o_period_tick = r_tick;
    assign o_running     = (r_state != IDLE);

    // Per-bridge local count (wrapped once into 0..2P-1), level and desired switch pattern
    always_comb begin
        w_lvl_v = '0;
        w_des   = '0;
        for (int k = 0; k < N_BR; k++) begin
            w_d[k]   = w_cnt_s - SW'(r_ph[k]);
            w_l[k]   = w_d[k][SW-1] ? w_d[k] + w_p2 : (w_d[k] >= w_p2) ? w_d[k] - w_p2 : w_d[k];
            w_t[k]   = $signed({2'b00, r_tau[k]});
            w_lvl[k] = (r_state == IDLE)          ? 2'b00 :
                       (w_l[k] < w_p_s - w_t[k]) ? 2'b00 :
                       (w_l[k] < w_p_s)          ? 2'b01 :
                       (w_l[k] < w_p2 - w_t[k])  ? 2'b00 : 2'b11;
            w_lvl_v[2*k +: 2] = w_lvl[k];
            w_des[4*k +: 4]   = (r_state == IDLE)    ? 4'b0000 :
                                (w_lvl[k] == 2'b01)  ? 4'b1001 :
                                (w_lvl[k] == 2'b11)  ? 4'b0110 : 4'b1010;
        end
    end

    // FSM, carrier counter, wrap tick, shadow-full flag and registered levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_full  <= 1'b0;
            r_vlev  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= ((r_state == IDLE) || w_wrap || w_realign) ? '0 : r_cnt + 1'b1;
            r_tick  <= w_wrap && !w_realign;
            r_full  <= w_cap || (r_full && !w_apply);
            r_vlev  <= w_lvl_v;
        end
    end

    // Clamped capture into the shadow, and shadow-to-active copy at period boundaries
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_p <= '0;
            r_p    <= '0;
            for (int k = 0; k < N_BR; k++) begin
                r_sh_tau[k] <= '0;
                r_tau[k]    <= '0;
                r_sh_ph[k]  <= '0;
                r_ph[k]     <= '0;
            end
        end else begin
            if (w_cap) begin
                r_sh_p <= w_p_cl;
                for (int k = 0; k < N_BR; k++) begin
                    r_sh_tau[k] <= (i_tau[k*CNT_W +: CNT_W] > w_p_cl) ? w_p_cl : i_tau[k*CNT_W +: CNT_W];
                    r_sh_ph[k]  <= (k == 0) ? '0 : $signed(i_phase[k*(CNT_W+1) +: CNT_W+1]);
                end
            end
            if (w_apply) begin
                r_p <= r_sh_p;
                for (int k = 0; k < N_BR; k++) begin
                    r_tau[k] <= r_sh_tau[k];
                    r_ph[k]  <= r_sh_ph[k];
                end
            end
        end
    end

`ifdef DAB_DEADTIME_EN
    logic [DT_W-1:0]   r_sh_dt;
    logic [DT_W-1:0]   r_dt;
    logic [DT_W-1:0]   r_dtc [2*N_BR];
    logic [4*N_BR-1:0] r_prev;

    // Dead-time setting follows the same shadow/active handshake as the rest
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_dt <= '0;
            r_dt    <= '0;
        end else begin
            if (w_cap) r_sh_dt <= i_deadtime;
            if (w_apply) r_dt <= r_sh_dt;
        end
    end

    // Per-leg break-before-make: any change of the desired pair blanks the leg for r_dt cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gate <= '0;
            r_prev <= '0;
            for (int j = 0; j < 2*N_BR; j++) r_dtc[j] <= '0;
        end else begin
            r_prev <= w_des;
            for (int j = 0; j < 2*N_BR; j++) begin
                if ((w_des[2*j +: 2] != r_prev[2*j +: 2]) && (r_dt != '0)) begin
                    r_gate[2*j +: 2] <= 2'b00;
                    r_dtc[j]         <= r_dt - 1'b1;
                end else if ((w_des[2*j +: 2] == r_prev[2*j +: 2]) && (r_dtc[j] != '0)) begin
                    r_gate[2*j +: 2] <= 2'b00;
                    r_dtc[j]         <= r_dtc[j] - 1'b1;
                end else begin
                    r_gate[2*j +: 2] <= w_des[2*j +: 2];
                    r_dtc[j]         <= '0;
                end
            end
        end
    end
`else
    logic w_unused_dt;
    assign w_unused_dt = ^i_deadtime;

    // Gates follow the level mapping one cycle after the carrier
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_gate <= '0;
        else r_gate <= w_des;
    end
`endif
endmodule

// File: tb/tb_dab_phase_shift_pwm.sv
// tb_dab_phase_shift_pwm: randomized and directed checks of dab_phase_shift_pwm against an arithmetic model.
module tb_dab_phase_shift_pwm;
    localparam int CNT_W = 19;
    localparam int N_BR  = 2;
    localparam int DT_W  = 8;

    logic                      clk;
    logic                      rst_n;
    logic                      en;
    logic                      sync;
    logic [CNT_W-1:0]          half_period;
    logic [N_BR*CNT_W-1:0]     tau;
    logic [N_BR*(CNT_W+1)-1:0] phase;
    logic [DT_W-1:0]           deadtime;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [4*N_BR-1:0]         gate;
    logic [2*N_BR-1:0]         v_level;
    logic                      period_tick;
    logic                      running;
    int total = 0;
    int bad = 0;

    dab_phase_shift_pwm #(.CNT_W(CNT_W), .N_BR(N_BR), .DT_W(DT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync),
        .i_half_period(half_period), .i_tau(tau), .i_phase(phase), .i_deadtime(deadtime),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .o_gate(gate), .o_v_level(v_level),
        .o_period_tick(period_tick), .o_running(running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Level of one bridge given its local position x = cnt - phase, from the interval rules
    function automatic logic [1:0] m_one(int x, int p, int t);
        int m;
        int l;
        m = 2 * p;
        l = ((x % m) + m) % m;
        if (l < p - t) return 2'b00;
        if (l < p) return 2'b01;
        if (l < m - t) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [3:0] m_lv(int c, int p, int t0, int t1, int ph);
        return {m_one(c - ph, p, t1), m_one(c, p, t0)};
    endfunction

    function automatic logic [3:0] m_g1(logic [1:0] v);
        return (v == 2'b01) ? 4'b1001 : (v == 2'b11) ? 4'b0110 : 4'b1010;
    endfunction

    function automatic logic [7:0] m_gt(logic [3:0] v);
        return {m_g1(v[3:2]), m_g1(v[1:0])};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        sync = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic configure(int p, int t0, int t1, int ph1, int dt);
        half_period = CNT_W'(p);
        tau = {CNT_W'(t1), CNT_W'(t0)};
        phase = {(CNT_W+1)'(ph1), (CNT_W+1)'(0)};
        deadtime = DT_W'(dt);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic start();
        en = 1'b1;
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        sync = 1'b1;
        cfg_valid = 1'b0;
        half_period = '0;
        tau = '0;
        phase = '0;
        deadtime = '0;
        step();
        step();
        total++; if (gate !== 8'h00) begin bad++; $display("FAIL reset_gate got=%h want=00", gate); end
        total++; if (v_level !== 4'h0) begin bad++; $display("FAIL reset_vlevel got=%h want=0", v_level); end
        total++; if (period_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", period_tick); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
        en = 1'b0;
        sync = 1'b0;
        rst_n = 1'b1;
        step();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL release_running got=%b want=0", running); end
        total++; if (gate !== 8'h00) begin bad++; $display("FAIL release_gate got=%h want=00", gate); end
    endtask

    task automatic test_patterns();
        for (int i = 0; i < 12; i++) begin
            int p;
            int t0;
            int t1;
            int ph;
            int pm;
            int m;
            int tm0;
            int tm1;
            logic [3:0] ev;
            p = 10; t0 = 2; t1 = 2; ph = 5;
            if (i == 1) ph = -5;
            if (i == 2) begin t0 = 15; t1 = 15; end
            if (i == 3) begin p = 1; t0 = 1; t1 = 0; ph = 1; end
            if (i >= 4) begin
                p  = int'($urandom_range(2, 25));
                t0 = int'($urandom_range(0, p + 3));
                t1 = int'($urandom_range(0, p + 3));
                ph = int'($urandom_range(0, 4 * p - 2)) - (2 * p - 1);
            end
            pm  = (p < 2) ? 2 : p;
            m   = 2 * pm;
            tm0 = (t0 > pm) ? pm : t0;
            tm1 = (t1 > pm) ? pm : t1;
            do_reset();
            configure(p, t0, t1, ph, 0);
            step();
            start();
            total++; if (running !== 1'b1) begin bad++; $display("FAIL pat%0d running got=%b want=1", i, running); end
            total++; if (v_level !== 4'h0) begin bad++; $display("FAIL pat%0d first_vlevel got=%b want=0000", i, v_level); end
            for (int s = 2; s < 2 * m + 4; s++) begin
                step();
                ev = m_lv((s - 2) % m, pm, tm0, tm1, ph);
                total++; if (v_level !== ev) begin bad++; $display("FAIL pat%0d v_level s=%0d got=%b want=%b", i, s, v_level, ev); end
                total++; if (gate !== m_gt(ev)) begin bad++; $display("FAIL pat%0d gate s=%0d got=%b want=%b", i, s, gate, m_gt(ev)); end
                total++; if (period_tick !== ((s - 1) % m == 0)) begin bad++; $display("FAIL pat%0d tick s=%0d got=%b want=%b", i, s, period_tick, ((s - 1) % m == 0)); end
            end
        end
    endtask

    task automatic test_cfg_timing();
        logic [3:0] ev;
        do_reset();
        configure(10, 2, 2, 5, 0);
        step();
        start();
        for (int s = 2; s <= 50; s++) begin
            step();
            ev = (s <= 21) ? m_lv((s - 2) % 20, 10, 2, 2, 5) : m_lv((s - 22) % 24, 12, 2, 2, 5);
            total++; if (v_level !== ev) begin bad++; $display("FAIL cfg v_level s=%0d got=%b want=%b", s, v_level, ev); end
            total++; if (period_tick !== (s == 21 || s == 45)) begin bad++; $display("FAIL cfg tick s=%0d got=%b want=%b", s, period_tick, (s == 21 || s == 45)); end
            total++; if (cfg_ready !== !(s >= 7 && s <= 20)) begin bad++; $display("FAIL cfg ready s=%0d got=%b want=%b", s, cfg_ready, !(s >= 7 && s <= 20)); end
            if (s == 6) begin half_period = CNT_W'(12); cfg_valid = 1'b1; end
            if (s == 7) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_stop();
        logic [3:0] ev;
        do_reset();
        configure(10, 2, 2, 5, 0);
        step();
        start();
        for (int s = 2; s <= 26; s++) begin
            step();
            ev = (s <= 21) ? m_lv((s - 2) % 20, 10, 2, 2, 5) : 4'h0;
            total++; if (v_level !== ev) begin bad++; $display("FAIL stop v_level s=%0d got=%b want=%b", s, v_level, ev); end
            total++; if (gate !== ((s <= 21) ? m_gt(ev) : 8'h00)) begin bad++; $display("FAIL stop gate s=%0d got=%b want=%b", s, gate, ((s <= 21) ? m_gt(ev) : 8'h00)); end
            total++; if (running !== (s <= 20)) begin bad++; $display("FAIL stop running s=%0d got=%b want=%b", s, running, (s <= 20)); end
            total++; if (period_tick !== (s == 21)) begin bad++; $display("FAIL stop tick s=%0d got=%b want=%b", s, period_tick, (s == 21)); end
            if (s == 8) en = 1'b0;
        end
    endtask

    task automatic test_realign();
        logic [3:0] ev;
        do_reset();
        configure(10, 2, 2, 5, 0);
        step();
        start();
        for (int s = 2; s <= 40; s++) begin
            step();
            ev = (s <= 14) ? m_lv((s - 2) % 20, 10, 2, 2, 5) : m_lv((s - 15) % 20, 10, 2, 2, 5);
            total++; if (v_level !== ev) begin bad++; $display("FAIL realign v_level s=%0d got=%b want=%b", s, v_level, ev); end
            total++; if (period_tick !== (s == 34)) begin bad++; $display("FAIL realign tick s=%0d got=%b want=%b", s, period_tick, (s == 34)); end
            total++; if (running !== 1'b1) begin bad++; $display("FAIL realign running s=%0d got=%b want=1", s, running); end
            if (s == 13) sync = 1'b1;
            if (s == 14) sync = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] ev;
        do_reset();
        configure(10, 2, 2, 5, 0);
        step();
        start();
        for (int s = 2; s <= 9; s++) step();
        ev = m_lv(7, 10, 2, 2, 5);
        total++; if (gate !== m_gt(ev)) begin bad++; $display("FAIL arst pre_gate got=%b want=%b", gate, m_gt(ev)); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (gate !== 8'h00) begin bad++; $display("FAIL arst gate got=%b want=00000000", gate); end
        total++; if (v_level !== 4'h0) begin bad++; $display("FAIL arst v_level got=%b want=0000", v_level); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL arst running got=%b want=0", running); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL arst ready got=%b want=1", cfg_ready); end
        #2;
        en = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

`ifdef DAB_DEADTIME_EN
    task automatic test_deadtime();
        logic [1:0] ea;
        do_reset();
        configure(10, 4, 4, 0, 3);
        step();
        start();
        for (int s = 2; s <= 60; s++) begin
            step();
            total++; if (gate[0] && gate[1]) begin bad++; $display("FAIL dt legA_overlap s=%0d got=%b want=no S1&S2", s, gate[1:0]); end
            total++; if (gate[2] && gate[3]) begin bad++; $display("FAIL dt legB_overlap s=%0d got=%b want=no S3&S4", s, gate[3:2]); end
            if (s >= 7 && s <= 15) begin
                ea = (s == 7 || s == 15) ? 2'b10 : (s == 11) ? 2'b01 : 2'b00;
                total++; if (gate[1:0] !== ea) begin bad++; $display("FAIL dt legA s=%0d got=%b want=%b", s, gate[1:0], ea); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_patterns();
        test_cfg_timing();
        test_stop();
        test_realign();
        test_async_reset();
`ifdef DAB_DEADTIME_EN
        test_deadtime();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
